// File: rtl/pe_pkg.sv
// Shared types and constants for the PE array result path.
// One FIFO entry holds a 256-bit PE row, its {round, row} tag and a frame-last flag.
package pe_pkg;

    localparam int PE_COLS = 16;
    localparam int PE_ROWS = 2;
    localparam int DATA_W  = 16;
    localparam int ROW_W   = PE_COLS * DATA_W;

    typedef logic [PE_COLS-1:0][DATA_W-1:0] pe_row_t;

    typedef struct packed {
        logic [2:0] round;
        logic       row_idx;
    } pe_tag_t;

    typedef struct packed {
        pe_row_t data;
        pe_tag_t tag;
        logic    last;
    } pe_entry_t;

    localparam int ENTRY_W = $bits(pe_entry_t);

    function automatic pe_entry_t make_entry(input pe_row_t data, input logic [2:0] round,
                                             input logic row_idx, input logic last);
        pe_entry_t e;
        e.data        = data;
        e.tag.round   = round;
        e.tag.row_idx = row_idx;
        e.last        = last;
        return e;
    endfunction

endpackage

// File: rtl/dual_push_fifo.sv
// Circular buffer that accepts two entries per cycle and releases one.
// The caller guarantees space before push2; level alone separates full from empty.
module dual_push_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push2,
    input  logic [W-1:0]     din0,
    input  logic [W-1:0]     din1,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push2 && !flush;
    assign do_pop  = pop && !flush && (level != '0);

    // Storage carries no reset; level gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr]               <= din0;
            mem[wr_ptr + PTR_W'(1)]   <= din1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(2);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b11:   level <= level + LVL_W'(1);
                2'b10:   level <= level + LVL_W'(2);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/pe_result_collector.sv
// Splits each PE array capture into two tagged rows, buffers them and streams
// them to writeback; drops whole captures (sticky overflow) when space is short.
module pe_result_collector
    import pe_pkg::*;
#(
    parameter  int DEPTH        = 8,
    parameter  int FRAME_ROUNDS = 8,
    localparam int LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [PE_ROWS-1:0][PE_COLS-1:0][DATA_W-1:0] pe_array_out,
    input  logic                                      rounder_valid,
    input  logic [2:0]                                round_number,
    input  logic                                      clear,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ROW_W-1:0]                          out_data,
    output logic [3:0]                                out_tag,
    output logic                                      out_last,
    output logic [LVL_W-1:0]                          fifo_level,
    output logic                                      overflow
);

    localparam logic [LVL_W-1:0] PUSH_MAX   = LVL_W'(DEPTH - 2);
    localparam logic [7:0]       FRAME_LAST = 8'(FRAME_ROUNDS - 1);

    logic [7:0]         frame_cnt;
    logic               frame_end;
    logic               has_space;
    logic               capture_ok;
    logic               capture_drop;
    logic               pop;
    pe_entry_t          entry0;
    pe_entry_t          entry1;
    logic [ENTRY_W-1:0] rd_raw;
    pe_entry_t          rd_entry;

    // Space check uses the pre-pop level so a capture is all-or-nothing.
    assign has_space    = (fifo_level <= PUSH_MAX);
    assign capture_ok   = rounder_valid && !clear && has_space;
    assign capture_drop = rounder_valid && !clear && !has_space;
    assign frame_end    = (frame_cnt == FRAME_LAST);
    assign pop          = out_valid && out_ready && !clear;

    assign entry0 = make_entry(pe_array_out[0], round_number, 1'b0, 1'b0);
    assign entry1 = make_entry(pe_array_out[1], round_number, 1'b1, frame_end);

    dual_push_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .push2 (capture_ok),
        .din0  (entry0),
        .din1  (entry1),
        .pop   (pop),
        .dout  (rd_raw),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (capture_ok)
                frame_cnt <= frame_end ? 8'd0 : frame_cnt + 8'd1;
            if (capture_drop)
                overflow <= 1'b1;
        end
    end

    assign rd_entry  = rd_raw;
    assign out_valid = (fifo_level != '0);
    assign out_data  = out_valid ? rd_entry.data : '0;
    assign out_tag   = out_valid ? rd_entry.tag  : '0;
    assign out_last  = out_valid ? rd_entry.last : 1'b0;

endmodule
